// File: rtl/step_gen_pkg.sv
// Shared state encoding and default timing values for the step/direction
// pulse generator.
package step_gen_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, AUTO, MOVE, MOVE_N, DRAIN} state_t;

   localparam int DEF_PULSE_W = 500;
   localparam int DEF_PERIOD  = 2000;

endpackage

// File: rtl/step_timer.sv
// Period counter for one STEP channel: clamps width/period, raises STEP on go,
// and flags the final cycle of each period so the caller can chain the next.
module step_timer #(
   parameter int SIZE = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            go,
   input  logic [SIZE-1:0] raw_period,
   input  logic [SIZE-1:0] pulse_w,
   output logic            step,
   output logic            act,
   output logic            last
);

   localparam logic [SIZE:0] ONE = (SIZE+1)'(1);

   logic [SIZE:0]   tmr, tmr_inc, w_eff, p_eff;
   logic [SIZE-1:0] p_lat;

   // One extra bit so W+1 cannot wrap when pulse_w is all ones.
   always_comb begin
      w_eff   = (pulse_w == '0) ? ONE : {1'b0, pulse_w};
      p_eff   = ({1'b0, p_lat} > w_eff) ? {1'b0, p_lat} : w_eff + ONE;
      tmr_inc = tmr + ONE;
      last    = act && (tmr == p_eff - ONE);
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         tmr   <= '0;
         step  <= 1'b0;
         act   <= 1'b0;
         p_lat <= '0;
      end else if (go) begin
         tmr   <= '0;
         step  <= 1'b1;
         act   <= 1'b1;
         p_lat <= raw_period;
      end else if (act) begin
         tmr   <= tmr_inc;
         step  <= (tmr_inc < w_eff);
      end
   end

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator: mode FSM, acceleration ramp, step counter
// and move-N completion around a single step_timer.
module step_pulse_gen
   import step_gen_pkg::*;
#(
   parameter int SIZE      = 16,
   parameter int CNT_W     = 16,
   parameter int DIR_SETUP = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             drv_en_SM,
   input  logic             avto,
   input  logic             start,
   input  logic             start_N,
   input  logic             stop,
   input  logic             dir_in,
   input  logic [SIZE-1:0]  period,
   input  logic [SIZE-1:0]  pulse_w,
   input  logic [SIZE-1:0]  period_start,
   input  logic [SIZE-1:0]  period_min,
   input  logic [SIZE-1:0]  accel,
   input  logic [CNT_W-1:0] n_steps,
   output logic             step,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] step_cnt
);

   localparam int             SC_W    = $clog2(DIR_SETUP + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(DIR_SETUP - 1);

   state_t            state, mode;
   logic [SC_W-1:0]   setup_cnt;
   logic [SIZE-1:0]   pw_lat, pmin_lat, acc_lat, cur, ramp_nxt, diff, raw;
   logic [CNT_W-1:0]  n_lat;
   logic              go, clr, t_act, t_last, entry, setup_abort;

   assign busy  = (state != IDLE);
   assign entry = avto || (!stop && (start || start_N));

   always_comb begin
      diff        = cur - acc_lat;
      ramp_nxt    = (cur < acc_lat || diff < pmin_lat) ? pmin_lat : diff;
      raw         = (mode == AUTO) ? period : cur;
      setup_abort = stop || (mode == AUTO && !avto);
      go          = 1'b0;
      clr         = 1'b0;
      case (state)
         IDLE:   clr = 1'b1;
         SETUP:  if (!setup_abort && setup_cnt == SC_LAST)
                    go = (mode == MOVE_N) ? (n_lat != '0) :
                         (mode == AUTO)   ? drv_en_SM : 1'b1;
         AUTO: begin
            clr = !drv_en_SM;
            go  = drv_en_SM && avto && (!t_act || t_last);
         end
         MOVE:   go = !stop && t_last;
         MOVE_N: go = !stop && t_last && (step_cnt != n_lat);
         default: ;
      endcase
   end

   step_timer #(.SIZE(SIZE)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .go         (go),
      .raw_period (raw),
      .pulse_w    (pw_lat),
      .step       (step),
      .act        (t_act),
      .last       (t_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mode      <= IDLE;
         setup_cnt <= '0;
         dir       <= 1'b0;
         done      <= 1'b0;
         step_cnt  <= '0;
         pw_lat    <= '0;
         pmin_lat  <= '0;
         acc_lat   <= '0;
         cur       <= '0;
         n_lat     <= '0;
      end else begin
         done <= 1'b0;
         if (go) begin
            step_cnt <= step_cnt + CNT_W'(1);
            if (mode != AUTO) cur <= ramp_nxt;
         end
         case (state)
            IDLE: if (entry) begin
               state     <= SETUP;
               mode      <= avto ? AUTO : (start ? MOVE : MOVE_N);
               setup_cnt <= '0;
               dir       <= dir_in;
               step_cnt  <= '0;
               pw_lat    <= pulse_w;
               pmin_lat  <= period_min;
               acc_lat   <= accel;
               n_lat     <= n_steps;
               cur       <= (period_start < period_min) ? period_min : period_start;
            end
            SETUP:
               if (setup_abort) state <= IDLE;
               else if (setup_cnt == SC_LAST) begin
                  if (mode == MOVE_N && n_lat == '0) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else
                     state <= mode;
               end else
                  setup_cnt <= setup_cnt + SC_W'(1);
            AUTO: if (!avto) state <= DRAIN;
            MOVE: if (stop) state <= DRAIN;
            MOVE_N:
               if (stop) state <= DRAIN;
               // Completion waits for the full low time of the last period.
               else if (t_last && step_cnt == n_lat) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            DRAIN: if (!step) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: table of move-N runs plus hand-written
// ramp, AUTO, clamp, start/stop collision and reset sequences.
module tb_step_pulse_gen;

   localparam int SIZE = 16, CNT_W = 16, DIR_SETUP = 8;

   logic             clk = 1'b0;
   logic             rst, drv_en_SM, avto, start, start_N, stop, dir_in;
   logic [SIZE-1:0]  period, pulse_w, period_start, period_min, accel;
   logic [CNT_W-1:0] n_steps;
   logic             step, dir, busy, done;
   logic [CNT_W-1:0] step_cnt;

   always #5 clk = ~clk;

   step_pulse_gen #(.SIZE(SIZE), .CNT_W(CNT_W), .DIR_SETUP(DIR_SETUP)) dut (
      .clk(clk), .rst(rst), .drv_en_SM(drv_en_SM), .avto(avto), .start(start),
      .start_N(start_N), .stop(stop), .dir_in(dir_in), .period(period),
      .pulse_w(pulse_w), .period_start(period_start), .period_min(period_min),
      .accel(accel), .n_steps(n_steps), .step(step), .dir(dir), .busy(busy),
      .done(done), .step_cnt(step_cnt)
   );

   typedef struct {
      int n, pw, ps, pmin, acc;
      int rises, first, w, done_at;
      int p0, p1, p2, p3;
   } vec_t;

   vec_t tv[6];
   int   n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic setv(input int i, input int n, pw, ps, pmin, acc,
                       input int rises, first, w, done_at, p0, p1, p2, p3);
      tv[i].n = n; tv[i].pw = pw; tv[i].ps = ps; tv[i].pmin = pmin; tv[i].acc = acc;
      tv[i].rises = rises; tv[i].first = first; tv[i].w = w; tv[i].done_at = done_at;
      tv[i].p0 = p0; tv[i].p1 = p1; tv[i].p2 = p2; tv[i].p3 = p3;
   endtask

   function automatic int exp_per(input int i, input int k);
      case (k)
         0: return tv[i].p0;
         1: return tv[i].p1;
         2: return tv[i].p2;
         default: return tv[i].p3;
      endcase
   endfunction

   task automatic run_moven(input int i);
      int rt[8];
      int nr, hw, done_c, done_n, cnt_at, busy_at, prev;
      nr = 0; hw = 0; done_c = -1; done_n = 0; cnt_at = -1; busy_at = -1; prev = 0;
      @(negedge clk);
      n_steps = CNT_W'(tv[i].n); pulse_w = SIZE'(tv[i].pw);
      period_start = SIZE'(tv[i].ps); period_min = SIZE'(tv[i].pmin);
      accel = SIZE'(tv[i].acc); start_N = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         start_N = 1'b0;
         if (step && !prev) begin
            if (nr < 8) rt[nr] = c;
            nr++;
         end
         if (step && nr == 1) hw++;
         prev = step;
         if (done) begin
            done_n++;
            if (done_c < 0) begin done_c = c; cnt_at = step_cnt; busy_at = busy; end
         end
         if (done_c >= 0 && c >= done_c + 3) break;
      end
      chk($sformatf("v%0d rises", i), nr, tv[i].rises);
      chk($sformatf("v%0d done_at", i), done_c, tv[i].done_at);
      chk($sformatf("v%0d done_len", i), done_n, 1);
      chk($sformatf("v%0d cnt_at_done", i), cnt_at, tv[i].n);
      chk($sformatf("v%0d busy_at_done", i), busy_at, 0);
      if (tv[i].rises > 0) begin
         chk($sformatf("v%0d first_rise", i), rt[0], tv[i].first);
         chk($sformatf("v%0d width", i), hw, tv[i].w);
      end
      for (int k = 0; k < 4 && k + 1 < nr && k + 1 < tv[i].rises; k++)
         chk($sformatf("v%0d period%0d", i, k), rt[k+1] - rt[k], exp_per(i, k));
   endtask

   initial begin
      int rt[8];
      int exp_mv[6] = '{20, 17, 14, 11, 8, 8};
      int nr, hw, prev, extra, gone, r;

      rst = 1'b1; drv_en_SM = 1'b0; avto = 1'b0; start = 1'b0; start_N = 1'b0;
      stop = 1'b0; dir_in = 1'b0; period = '0; pulse_w = '0; period_start = '0;
      period_min = '0; accel = '0; n_steps = '0;
      repeat (3) @(negedge clk);
      chk("rst step", step, 0);
      chk("rst dir", dir, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst step_cnt", step_cnt, 0);
      rst = 1'b0;

      //      n  pw  ps pmin acc rises first w done  periods
      setv(0, 3, 4, 10,  0, 0,  3, 9, 4, 39, 10, 10, 0, 0);
      setv(1, 4, 0,  0,  0, 0,  4, 9, 1, 17,  2,  2, 2, 0);
      setv(2, 5, 2, 20,  8, 3,  5, 9, 2, 79, 20, 17, 14, 11);
      setv(3, 3, 3,  5,  9, 1,  3, 9, 3, 36,  9,  9, 0, 0);
      setv(4, 2, 6,  4,  0, 0,  2, 9, 6, 23,  7,  0, 0, 0);
      setv(5, 0, 4, 10,  0, 0,  0, 0, 0,  9,  0,  0, 0, 0);
      for (int i = 0; i < 6; i++) run_moven(i);

      // MOVE ramp, then stop one cycle into a high pulse.
      @(negedge clk);
      pulse_w = 5; period_start = 20; accel = 3; period_min = 8; dir_in = 1'b1; start = 1'b1;
      nr = 0; prev = 0;
      for (int c = 1; c <= 200 && nr < 7; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (step && !prev) begin rt[nr] = c; nr++; end
         prev = step;
      end
      chk("move rises", nr, 7);
      chk("move dir", dir, 1);
      for (int k = 0; k < 6 && k + 1 < nr; k++)
         chk($sformatf("move period%0d", k), rt[k+1] - rt[k], exp_mv[k]);
      hw = step;
      @(negedge clk);
      hw += step; stop = 1'b1; prev = step; extra = 0; gone = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         stop = 1'b0;
         if (step && !prev) extra++;
         hw += step; prev = step;
         if (!busy) begin gone = 1; break; end
      end
      chk("move stop width", hw, 5);
      chk("move stop extra rise", extra, 0);
      chk("move stop idle", gone, 1);

      // AUTO with enable drop and avto release.
      @(negedge clk);
      pulse_w = 3; period = 12; drv_en_SM = 1'b1; avto = 1'b1; dir_in = 1'b0;
      nr = 0; prev = 0; hw = 0;
      for (int c = 1; c <= 100 && nr < 2; c++) begin
         @(negedge clk);
         if (step && !prev) begin rt[nr] = c; nr++; end
         if (step && nr == 1) hw++;
         prev = step;
      end
      chk("auto rises", nr, 2);
      chk("auto first", rt[0], 9);
      chk("auto period", rt[1] - rt[0], 12);
      chk("auto width", hw, 3);
      @(negedge clk);
      drv_en_SM = 1'b0; hw = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         hw += step;
      end
      drv_en_SM = 1'b1;
      chk("auto disabled highs", hw, 0);
      @(negedge clk);
      chk("auto reenable rise", step, 1);
      hw = step;
      @(negedge clk);
      hw += step; avto = 1'b0; prev = step; extra = 0; gone = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (step && !prev) extra++;
         hw += step; prev = step;
         if (!busy) begin gone = 1; break; end
      end
      chk("auto end width", hw, 3);
      chk("auto end extra rise", extra, 0);
      chk("auto end idle", gone, 1);

      // Clamp: W=1, P=2 square wave.
      @(negedge clk);
      pulse_w = 0; period = 0; avto = 1'b1; r = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (step) begin r = c; break; end
      end
      chk("clamp first", r, 9);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("clamp step%0d", k), step, (k % 2 == 0) ? 1 : 0);
      end
      avto = 1'b0; gone = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!busy) begin gone = 1; break; end
      end
      chk("clamp idle", gone, 1);

      // start/start_N colliding with stop in IDLE.
      @(negedge clk);
      start = 1'b1; start_N = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; start_N = 1'b0; stop = 1'b0;
      hw = 0;
      for (int c = 0; c < 4; c++) begin
         hw += busy;
         @(negedge clk);
      end
      chk("collide busy", hw, 0);

      // Synchronous reset in the middle of a high pulse.
      pulse_w = 5; period_start = 10; accel = 0; period_min = 0; dir_in = 1'b1; start = 1'b1;
      r = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (step) begin r = c; break; end
      end
      chk("rst-mid first", r, 9);
      chk("rst-mid dir before", dir, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst-mid step", step, 0);
      chk("rst-mid dir", dir, 0);
      chk("rst-mid busy", busy, 0);
      chk("rst-mid step_cnt", step_cnt, 0);
      rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Parametrised step/direction pulse generator for the RF2-RF3 stepper drive, the next generation of the TR step-pulse block. It drives one motor channel in three modes: free-running auto, continuous jog, and move-N. It adds runtime period, pulse width and step count, direction output with setup delay, a linear acceleration ramp, and a busy/done handshake. It sits between the motion control registers and the stepper driver's STEP/DIR pins.

## Interface
Parameters:
- SIZE, 16: width of the period, pulse-width and ramp quantities (cycles).
- CNT_W, 16: width of the step count and step counter.
- DIR_SETUP, 8: cycles DIR is held stable before the first STEP edge (must be at least 1).

Ports:
- clk  in  1: system clock.
- rst  in  1: reset, synchronous, active-high.
- drv_en_SM  in  1: driver enable; gates pulses in AUTO only.
- avto  in  1: level; AUTO mode while high.
- start  in  1: pulse; begin continuous MOVE.
- start_N  in  1: pulse; begin MOVE_N.
- stop  in  1: pulse; end MOVE/MOVE_N.
- dir_in  in  1: requested direction, latched at mode entry.
- period  in  SIZE: AUTO step period in cycles (live input).
- pulse_w  in  SIZE: STEP high time in cycles.
- period_start  in  SIZE: ramp start period (MOVE, MOVE_N).
- period_min  in  SIZE: ramp floor period.
- accel  in  SIZE: period decrement per step.
- n_steps  in  CNT_W: step count for MOVE_N.
- step  out  1: STEP output, registered.
- dir  out  1: DIR output, registered.
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle pulse when MOVE_N completes.
- step_cnt  out  CNT_W: number of rising STEP edges since the last mode entry.

## Operation
- States: IDLE, SETUP, AUTO, MOVE, MOVE_N, DRAIN.
- IDLE entry priority, sampled each cycle: avto, then start, then start_N. Entering any mode:
  - goes IDLE→SETUP;
  - latches dir_in into dir;
  - clears step_cnt;
  - latches pulse_w, n_steps, period_start, period_min and accel.
- SETUP holds for DIR_SETUP cycles with step=0, then enters the selected mode.
- Effective pulse width W = max(pulse_w, 1).
- Effective period P = max(raw period, W+1). Raw period is `period` in AUTO and the ramp value cur in MOVE/MOVE_N.
- Ramp:
  - cur = period_start at mode entry.
  - At each period boundary, cur = max(cur − accel, period_min), saturating with no underflow.
  - If period_start < period_min, cur = period_min from the first step.
  - There is no ramp in AUTO.
- AUTO:
  - `period` is sampled at each period boundary; a mid-period change takes effect on the next step.
  - drv_en_SM=0 holds the timer at 0 and step=0. On re-enable, a new period starts.
  - avto falling ends the mode: the current high pulse completes, then IDLE.
- MOVE: runs until stop, then DRAIN.
- MOVE_N:
  - After the n_steps-th period fully completes, including its low time, done pulses for one cycle and the state returns to IDLE.
  - n_steps=0: no pulses; done asserts on the cycle after SETUP ends.
  - stop goes to DRAIN; done is not asserted.
- DRAIN: if step is high, let it finish its W cycles. Then step=0 and IDLE. No new rising edge is issued.
- stop while in SETUP: return to IDLE with no pulses.
- stop wins over start/start_N in the same cycle. start/start_N/avto are ignored outside IDLE.
- step_cnt increments on each rising STEP edge and wraps at 2^CNT_W.

## Timing
- Reset values: step=0, dir=0, busy=0, done=0, step_cnt=0, state=IDLE.
- Reset mid-operation truncates any pulse immediately.
- Latency from start or start_N (cycle t):
  - busy=1 at t+1;
  - first step rising edge at t+1+DIR_SETUP.
- step is high for exactly W cycles; rising-to-rising spacing is exactly P cycles.
- done occurs at the cycle P cycles after the last rising edge, and coincides with busy falling.

## Structure
- Package step_gen_pkg holds:
  - the state enum (IDLE, SETUP, AUTO, MOVE, MOVE_N, DRAIN);
  - default localparams DEF_PULSE_W=500 and DEF_PERIOD=2000.
- Sub-module step_timer (period counter, W/P clamping, boundary strobe, rise strobe), instantiated once.
- The top level holds the FSM, ramp register, step counter and done logic.

## Test plan
- Reset then start_N: n_steps=3, pulse_w=4, period_start=10, accel=0, DIR_SETUP=8.
  - Expected: 3 pulses, each 4 high / 6 low; first rise 9 cycles after start_N; done exactly 10 cycles after the third rise; step_cnt=3.
- Ramp in MOVE: period_start=20, accel=3, period_min=8.
  - Expected: successive periods 20, 17, 14, 11, 8, 8, …; stop mid-high keeps the pulse at full width, then IDLE.
- AUTO with period=12, pulse_w=3: drop drv_en_SM for 30 cycles.
  - Expected: step=0 during the drop; first rise 1 cycle after re-enable; avto low ends the mode after the current pulse.
- Clamping with pulse_w=0 and period=0 in AUTO.
  - Expected: W=1, P=2, i.e. a 1-high/1-low square wave.
- Simultaneous start and stop in IDLE.
  - Expected: no mode entry, busy stays 0.
- n_steps=0 in MOVE_N.
  - Expected: zero pulses, done at SETUP+1.
- rst asserted mid-pulse.
  - Expected: all outputs 0 on the next cycle.
